// File: rtl/issue_ctrl_sb.sv
// rtl/issue_ctrl_sb.sv - N-wide in-order issue controller with a private register scoreboard
// Grants the longest hazard-free in-order prefix of the decode group each cycle.
module issue_ctrl_sb #(
  parameter int ISSUE_W   = 2,
  parameter int NREGS     = 32,
  parameter int ALU_LAT   = 0,
  parameter int LOAD_LAT  = 2,
  parameter int MEM_PORTS = 1,
  localparam int RW       = $clog2(NREGS),
  localparam int MAXLAT   = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT,
  localparam int CW       = $clog2(MAXLAT + 1),
  localparam int QW       = $clog2(ISSUE_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ISSUE_W-1:0]    in_valid,
  input  logic [ISSUE_W*RW-1:0] in_rs1,
  input  logic [ISSUE_W*RW-1:0] in_rs2,
  input  logic [ISSUE_W-1:0]    in_rs1_used,
  input  logic [ISSUE_W-1:0]    in_rs2_used,
  input  logic [ISSUE_W*RW-1:0] in_rd,
  input  logic [ISSUE_W-1:0]    in_rd_we,
  input  logic [ISSUE_W-1:0]    in_is_load,
  input  logic [ISSUE_W-1:0]    in_is_mem,
  input  logic [ISSUE_W-1:0]    in_is_ctrl,
  input  logic [ISSUE_W-1:0]    in_is_system,
  output logic [ISSUE_W-1:0]    issue_mask,
  output logic [QW-1:0]         issue_count,
  output logic                  stall_if,
  output logic [NREGS-1:0]      sb_busy,
  output logic [31:0]           stall_cycles
);

  logic [CW-1:0]       cnt      [NREGS];
  logic [RW-1:0]       rs1      [ISSUE_W];
  logic [RW-1:0]       rs2      [ISSUE_W];
  logic [RW-1:0]       rd       [ISSUE_W];
  logic [(1<<RW)-1:0]  busy_pad;
  logic [ISSUE_W-1:0]  src_busy;
  logic [ISSUE_W-1:0]  raw_hz;
  logic [ISSUE_W-1:0]  waw_hz;
  logic [ISSUE_W-1:0]  mem_hz;
  logic [ISSUE_W-1:0]  ctrl_hz;
  logic [ISSUE_W-1:0]  sys_hz;
  logic [ISSUE_W-1:0]  ok;
  logic [NREGS-1:0]    wr_hit;
  logic [CW-1:0]       wr_lat   [NREGS];

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_unpack
    assign rs1[i] = in_rs1[i*RW +: RW];
    assign rs2[i] = in_rs2[i*RW +: RW];
    assign rd[i]  = in_rd[i*RW +: RW];
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_busy
    assign sb_busy[r] = (cnt[r] != '0);
  end

  // Padded copy so any RW-bit index is in range even when NREGS is not a power of two
  always_comb begin
    busy_pad = '0;
    for (int r = 0; r < NREGS; r++) busy_pad[r] = sb_busy[r];
  end

  always_comb begin
    int mem_seen;
    mem_seen = 0;
    src_busy = '0;
    raw_hz   = '0;
    waw_hz   = '0;
    mem_hz   = '0;
    ctrl_hz  = '0;
    sys_hz   = '0;
    ok       = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      src_busy[i] = (in_rs1_used[i] && (rs1[i] != '0) && busy_pad[rs1[i]]) ||
                    (in_rs2_used[i] && (rs2[i] != '0) && busy_pad[rs2[i]]);
      for (int j = 0; j < i; j++) begin
        if (in_rd_we[j] && (rd[j] != '0)) begin
          if ((in_rs1_used[i] && (rs1[i] == rd[j])) || (in_rs2_used[i] && (rs2[i] == rd[j])))
            raw_hz[i] = 1'b1;
          if (in_rd_we[i] && (rd[i] == rd[j]))
            waw_hz[i] = 1'b1;
        end
        if (in_is_ctrl[j]) ctrl_hz[i] = 1'b1;
      end
      if (in_is_mem[i]) mem_seen = mem_seen + 1;
      mem_hz[i] = in_is_mem[i] && (mem_seen > MEM_PORTS);
      sys_hz[i] = (i > 0) && (in_is_system[i] || in_is_system[0]);
      ok[i] = in_valid[i] &&
              !(src_busy[i] || raw_hz[i] || waw_hz[i] || mem_hz[i] || ctrl_hz[i] || sys_hz[i]);
    end
  end

  // The first blocked slot blocks every younger slot, so the mask is always a prefix
  always_comb begin
    logic run;
    run         = !flush;
    issue_mask  = '0;
    issue_count = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      run           = run && ok[i];
      issue_mask[i] = run;
      issue_count   = issue_count + QW'(run);
    end
  end

  assign stall_if = in_valid[0] && !issue_mask[0] && !flush;

  // At most one issued writer per register thanks to the intra-group WAW check
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) wr_lat[r] = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (issue_mask[i] && in_rd_we[i] && (rd[i] == RW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_lat[r] = in_is_load[i] ? CW'(LOAD_LAT) : CW'(ALU_LAT);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r])
          cnt[r] <= wr_lat[r];
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall_if && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule
